// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } state_t;

   localparam int DEF_WIDTH = 16;

   // Bit counter must index bits 0..width-1 without ever wrapping.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the bit slice that the serial adder iterates over.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB first, one bit per clock through a single full adder,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder
   import serial_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zr
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nx;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;
   logic             c_msb_in;
   logic             cout_q;
   logic             ovf_q;
   logic             zr_q;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign last_bit = (cnt == LAST_BIT);
   // On the last RUN cycle the registered carry is the carry into the MSB.
   assign c_msb_in = carry;
   assign sum_nx   = {fa_sum, sum_sh[WIDTH-1:1]};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last_bit) state_nx = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zr_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_nx;
               carry  <= fa_cout;
               if (last_bit) begin
                  // Flags are registered on entry to HOLD so they stay bit-stable under backpressure.
                  cout_q <= fa_cout;
                  ovf_q  <= c_msb_in ^ fa_cout;
                  zr_q   <= (sum_nx == '0);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_sh;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zr   = zr_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, randomized operands,
// backpressure, mid-operation reset and back-to-back throughput against an arithmetic model.
module tb_serial_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zr;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zr;
   } res_t;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zr        (zr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: unsigned sum for sum/cout, true signed sum range for overflow.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      res_t         r;
      logic [W:0]   t;
      longint       sx;
      longint       sy;
      longint       ss;
      t      = {1'b0, x} + {1'b0, y} + (W + 1)'(c);
      r.sum  = t[W-1:0];
      r.cout = t[W];
      sx     = longint'($signed(x));
      sy     = longint'($signed(y));
      ss     = sx + sy + longint'(c);
      r.ovf  = (ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1)));
      r.zr   = (r.sum == '0);
      return r;
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string pfx, input res_t e);
      check({pfx, "_sum"},  32'(sum),  32'(e.sum));
      check({pfx, "_cout"}, 32'(cout), 32'(e.cout));
      check({pfx, "_ovf"},  32'(ovf),  32'(e.ovf));
      check({pfx, "_zr"},   32'(zr),   32'(e.zr));
   endtask

   task automatic scramble_inputs();
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      in_valid = 1'b1;
   endtask

   // One full operation; hold = cycles of out_ready=0 in HOLD, noise = drive junk operands after accept.
   task automatic do_op(input string pfx, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input int hold, input bit noise);
      res_t e;
      int   lat;
      e = model(x, y, c);
      check({pfx, "_ready"}, 32'(in_ready), 32'd1);
      a        = x;
      b        = y;
      cin      = c;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat      = 0;
      while (!out_valid && lat < 40) begin
         if (noise) scramble_inputs();
         cycle();
         lat++;
      end
      check({pfx, "_latency"}, 32'(lat), 32'(W));
      check_result(pfx, e);
      for (int i = 0; i < hold; i++) begin
         if (noise) scramble_inputs();
         cycle();
         check({pfx, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({pfx, "_hold_ready"}, 32'(in_ready), 32'd0);
         check_result({pfx, "_hold"}, e);
      end
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({pfx, "_done_valid"}, 32'(out_valid), 32'd0);
      check({pfx, "_done_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic check_reset_state(input string pfx);
      check({pfx, "_in_ready"},  32'(in_ready),  32'd1);
      check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      check({pfx, "_sum"},       32'(sum),       32'd0);
      check({pfx, "_cout"},      32'(cout),      32'd0);
      check({pfx, "_ovf"},       32'(ovf),       32'd0);
      check({pfx, "_zr"},        32'(zr),        32'd0);
   endtask

   task automatic back_to_back();
      logic [W-1:0] xs[3];
      logic [W-1:0] ys[3];
      logic         cs[3];
      res_t         expq[$];
      res_t         e;
      int           acc_cyc[$];
      int           idx;
      int           results;
      bit           accepted;
      for (int i = 0; i < 3; i++) begin
         xs[i] = W'($urandom);
         ys[i] = W'($urandom);
         cs[i] = 1'($urandom);
      end
      idx       = 0;
      results   = 0;
      a         = xs[0];
      b         = ys[0];
      cin       = cs[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && results < 3; cyc++) begin
         accepted = in_valid && in_ready;
         if (accepted) begin
            expq.push_back(model(a, b, cin));
            acc_cyc.push_back(cyc);
            idx++;
         end
         if (out_valid) begin
            if (expq.size() > 0) begin
               e = expq.pop_front();
               check("b2b_sum",  32'(sum),  32'(e.sum));
               check("b2b_cout", 32'(cout), 32'(e.cout));
               check("b2b_ovf",  32'(ovf),  32'(e.ovf));
               check("b2b_zr",   32'(zr),   32'(e.zr));
            end else begin
               check("b2b_unexpected_result", 32'(out_valid), 32'd0);
            end
            results++;
         end
         cycle();
         if (accepted) begin
            if (idx < 3) begin
               a   = xs[idx];
               b   = ys[idx];
               cin = cs[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_results", 32'(results), 32'd3);
      check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
      if (acc_cyc.size() >= 3) begin
         check("b2b_interval_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
         check("b2b_interval_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) cycle();
      check_reset_state("reset");
      rst = 1'b0;
      cycle();

      do_op("one_plus_one", 16'h0001, 16'h0001, 1'b0, 0, 1'b0);
      do_op("wrap_zero",    16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      do_op("pos_ovf",      16'h7FFF, 16'h0000, 1'b1, 0, 1'b0);
      do_op("neg_ovf",      16'h8000, 16'h8000, 1'b0, 0, 1'b0);

      do_op("backpressure", W'($urandom), W'($urandom), 1'($urandom), 5, 1'b1);

      for (int i = 0; i < 6; i++) begin
         do_op("random", W'($urandom), W'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 1'($urandom));
      end

      // Abort an operation while it is processing bit 7.
      a        = 16'hBEEF;
      b        = 16'hCAFE;
      cin      = 1'b1;
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (7) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_reset_state("mid_reset");
      do_op("after_reset", 16'h1234, 16'h4321, 1'b1, 0, 1'b0);
      check("after_reset_const_sum", 32'(model(16'h1234, 16'h4321, 1'b1).sum), 32'h5556);

      back_to_back();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
